// File: rtl/fsm_stim_driver.sv
// Stimulus driver and checker for the three-state x/y control FSM.
// Plays a command of up to MAXLEN x/y symbols onto the FSM, one per cycle.
// A shadow copy of the FSM predicts its registered output. Each prediction
// is compared against obs_out two edges after its symbol is loaded.
module fsm_stim_driver #(
    parameter int MAXLEN = 8,
    parameter int LENW   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [LENW-1:0]     req_len,
    input  logic [2*MAXLEN-1:0] req_seq,
    output logic                x,
    output logic                y,
    input  logic [1:0]          obs_out,
    output logic                done,
    output logic                err,
    output logic [LENW-1:0]     fail_idx,
    output logic [2:0]          cur_state,
    output logic [1:0]          exp_out
);

    localparam logic [2:0]      ST_A  = 3'b100;
    localparam logic [2:0]      ST_B  = 3'b010;
    localparam logic [2:0]      ST_C  = 3'b001;
    localparam logic [LENW-1:0] MAX_L = LENW'(MAXLEN);

    typedef enum logic [1:0] {IDLE, DRIVE, DRAIN} ctl_t;

    ctl_t                r_ctl;
    ctl_t                w_ctl_nxt;
    logic [2*MAXLEN-1:0] r_seq;         // remaining symbols, next one in [1:0]
    logic [LENW-1:0]     r_len;
    logic [LENW-1:0]     r_idx;         // index of the next symbol to load
    logic                r_load_valid;  // a symbol was loaded at the last edge
    logic [LENW-1:0]     r_load_idx;
    logic                r_chk_valid;   // FSM has sampled that symbol; compare now
    logic [1:0]          r_chk_exp;
    logic [LENW-1:0]     r_chk_idx;

    logic                w_accept;
    logic                w_more;
    logic                w_load;
    logic [LENW-1:0]     w_len;
    logic [1:0]          w_sym;
    logic [2:0]          w_sh_state;
    logic [1:0]          w_sh_out;

    assign w_len     = (req_len > MAX_L) ? MAX_L : req_len;
    assign req_ready = (r_ctl == IDLE);
    assign w_accept  = req_valid && req_ready;
    assign w_more    = (r_ctl == DRIVE) && (r_idx < r_len);
    // Symbol 0 is loaded straight from the request on the accepting edge.
    assign w_load    = (w_accept && (w_len != '0)) || w_more;
    assign w_sym     = (r_ctl == IDLE) ? req_seq[1:0] : r_seq[1:0];

    // Shadow FSM: next state/output for the symbol being loaded (y wins over x).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        w_sh_state = cur_state;
        w_sh_out   = exp_out;
        if (w_sym[0]) begin
            case (cur_state)
                ST_A:    begin w_sh_state = ST_C; w_sh_out = 2'b01; end
                ST_B:    begin w_sh_state = ST_A; w_sh_out = 2'b10; end
                ST_C:    begin w_sh_state = ST_A; w_sh_out = 2'b01; end
                default: ;
            endcase
        end else if (w_sym[1]) begin
            case (cur_state)
                ST_A:    begin w_sh_state = ST_B; w_sh_out = 2'b10; end
                ST_B:    begin w_sh_state = ST_C; w_sh_out = 2'b01; end
                ST_C:    begin w_sh_state = ST_B; w_sh_out = 2'b01; end
                default: ;
            endcase
        end
    end

    // Control FSM next state: IDLE -> DRIVE -> DRAIN -> IDLE.
    always_comb begin
        w_ctl_nxt = r_ctl;
        case (r_ctl)
            IDLE:    if (w_accept && (w_len != '0)) w_ctl_nxt = DRIVE;
            DRIVE:   if (!w_more) w_ctl_nxt = DRAIN;
            DRAIN:   w_ctl_nxt = IDLE;
            default: w_ctl_nxt = IDLE;
        endcase
    end

    // Control FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block order.
        if (!rst) r_ctl <= IDLE;
        else      r_ctl <= w_ctl_nxt;
    end

    // Symbol drive, shadow model, check pipeline and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x            <= 1'b0;
            y            <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            fail_idx     <= '0;
            cur_state    <= ST_A;
            exp_out      <= 2'b00;
            r_seq        <= '0;
            r_len        <= '0;
            r_idx        <= '0;
            r_load_valid <= 1'b0;
            r_load_idx   <= '0;
            r_chk_valid  <= 1'b0;
            r_chk_exp    <= 2'b00;
            r_chk_idx    <= '0;
        end else begin
            done <= 1'b0;

            // exp_out still holds the prediction for the symbol the FSM just sampled.
            r_chk_valid <= r_load_valid;
            r_chk_exp   <= exp_out;
            r_chk_idx   <= r_load_idx;

            if (r_chk_valid && (obs_out != r_chk_exp) && !err) begin
                err      <= 1'b1;
                fail_idx <= r_chk_idx;
            end

            if (w_accept) begin
                err      <= 1'b0;
                fail_idx <= '0;
                r_len    <= w_len;
                r_seq    <= req_seq >> 2;
                r_idx    <= LENW'(1);
                if (w_len == '0) done <= 1'b1;
            end else if (w_more) begin
                r_seq <= r_seq >> 2;
                r_idx <= r_idx + LENW'(1);
            end

            if (w_load) begin
                x            <= w_sym[1];
                y            <= w_sym[0];
                cur_state    <= w_sh_state;
                exp_out      <= w_sh_out;
                r_load_valid <= 1'b1;
                r_load_idx   <= w_accept ? '0 : r_idx;
            end else begin
                x            <= 1'b0;
                y            <= 1'b0;
                r_load_valid <= 1'b0;
            end

            // The last comparison registers on the edge that leaves DRAIN.
            if (r_ctl == DRAIN) done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fsm_stim_driver.sv
// Bench for fsm_stim_driver: drives the real x/y FSM from the driver's
// outputs, applies a table of directed commands, then hand-written
// back-to-back and reset-mid-command sequences.
module tb_fsm_stim_driver;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_len;
    logic [15:0] req_seq;
    logic        x;
    logic        y;
    logic [1:0]  obs_out;
    logic        done;
    logic        err;
    logic [3:0]  fail_idx;
    logic [2:0]  cur_state;
    logic [1:0]  exp_out;

    int n_cmp  = 0;
    int n_fail = 0;

    fsm_stim_driver #(.MAXLEN(8), .LENW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_len   (req_len),
        .req_seq   (req_seq),
        .x         (x),
        .y         (y),
        .obs_out   (obs_out),
        .done      (done),
        .err       (err),
        .fail_idx  (fail_idx),
        .cur_state (cur_state),
        .exp_out   (exp_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The FSM being driven, sharing the reset domain.
    typedef enum logic [1:0] {F_A, F_B, F_C} fst_t;
    fst_t       f_st;
    logic [1:0] f_out;
    logic       obs_force;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_st  <= F_A;
            f_out <= 2'b00;
        end else begin
            unique case ({x, y})
                2'b01, 2'b11: begin
                    if (f_st == F_A) begin f_st <= F_C; f_out <= 2'b01; end
                    else if (f_st == F_B) begin f_st <= F_A; f_out <= 2'b10; end
                    else begin f_st <= F_A; f_out <= 2'b01; end
                end
                2'b10: begin
                    if (f_st == F_A) begin f_st <= F_B; f_out <= 2'b10; end
                    else if (f_st == F_B) begin f_st <= F_C; f_out <= 2'b01; end
                    else begin f_st <= F_B; f_out <= 2'b01; end
                end
                default: ;
            endcase
        end
    end

    assign obs_out = obs_force ? 2'b11 : f_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  len;
        logic [15:0] seq;
        logic [15:0] outs;      // expected exp_out after each symbol edge
        logic [2:0]  fin_st;
        logic [1:0]  fin_out;
        logic        fin_err;
        logic [3:0]  fin_fidx;
        int          force_idx; // symbol whose check sees obs_out=11, -1 none
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    initial begin
        vec_t        v;
        int          eff;
        logic [15:0] s;
        logic [15:0] o;

        // Commands run in order; shadow state carries from one to the next.
        vecs[0] = '{4'd1,  16'h0002, 16'h0002, 3'b010, 2'b10, 1'b0, 4'd0, -1}; // A: x
        vecs[1] = '{4'd1,  16'h0003, 16'h0002, 3'b100, 2'b10, 1'b0, 4'd0, -1}; // B: x+y
        vecs[2] = '{4'd4,  16'h005A, 16'h0056, 3'b001, 2'b01, 1'b0, 4'd0, -1}; // A: x,x,y,y
        vecs[3] = '{4'd3,  16'h0018, 16'h0025, 3'b100, 2'b10, 1'b1, 4'd1,  1}; // C: hold,x,y
        vecs[4] = '{4'd2,  16'h0009, 16'h0005, 3'b010, 2'b01, 1'b0, 4'd0, -1}; // A: y,x
        vecs[5] = '{4'd15, 16'hAAAA, 16'h5555, 3'b010, 2'b01, 1'b0, 4'd0, -1}; // B: 8 x (clamped)
        vecs[6] = '{4'd0,  16'hFFFF, 16'h0000, 3'b010, 2'b01, 1'b0, 4'd0, -1}; // len 0

        rst       = 1'b0;
        req_valid = 1'b0;
        req_len   = '0;
        req_seq   = '0;
        obs_force = 1'b0;

        // Reset held while idle.
        repeat (3) tick();
        check("rst_xy",       {x, y},    2'b00);
        check("rst_done",     done,      1'b0);
        check("rst_err",      err,       1'b0);
        check("rst_fail_idx", fail_idx,  4'd0);
        check("rst_state",    cur_state, 3'b100);
        check("rst_exp_out",  exp_out,   2'b00);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("rst_ready", req_ready, 1'b1);

        // Table-driven commands.
        for (int vi = 0; vi < NV; vi++) begin
            v   = vecs[vi];
            eff = (v.len > 4'd8) ? 8 : int'(v.len);
            s   = v.seq;
            o   = v.outs;
            check("cmd_ready", req_ready, 1'b1);
            req_valid = 1'b1;
            req_len   = v.len;
            req_seq   = v.seq;
            tick();                     // E0
            req_valid = 1'b0;
            check("accept_err_clr",  err,      1'b0);
            check("accept_fidx_clr", fail_idx, 4'd0);
            if (eff == 0) begin
                check("len0_done", done,   1'b1);
                check("len0_xy",   {x, y}, 2'b00);
            end else begin
                for (int e = 0; e <= eff + 1; e++) begin
                    if (e > 0) tick();  // now just after Ee
                    obs_force = (v.force_idx >= 0) && (e == v.force_idx + 1);
                    if (e < eff) begin
                        check("sym_xy",      {x, y},  s[2*e +: 2]);
                        check("sym_exp_out", exp_out, o[2*e +: 2]);
                        check("sym_done",    done,    1'b0);
                    end else if (e == eff) begin
                        check("tail_xy",   {x, y}, 2'b00);
                        check("tail_done", done,   1'b0);
                    end else begin
                        check("done_pulse", done,      1'b1);
                        check("done_ready", req_ready, 1'b1);
                    end
                end
            end
            check("fin_state",    cur_state, v.fin_st);
            check("fin_exp_out",  exp_out,   v.fin_out);
            check("fin_err",      err,       v.fin_err);
            check("fin_fail_idx", fail_idx,  v.fin_fidx);
            tick();
            check("done_one_cycle", done, 1'b0);
        end

        // Back-to-back: second command accepted in the first's done cycle.
        req_valid = 1'b1;               // from B: y -> A/10
        req_len   = 4'd1;
        req_seq   = 16'h0001;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("b2b_done1",  done,      1'b1);
        check("b2b_ready1", req_ready, 1'b1);
        check("b2b_state1", cur_state, 3'b100);
        req_valid = 1'b1;               // from A: x -> B/10
        req_seq   = 16'h0002;
        tick();
        req_valid = 1'b0;
        check("b2b_done_low", done,      1'b0);
        check("b2b_xy",       {x, y},    2'b10);
        check("b2b_exp_out",  exp_out,   2'b10);
        check("b2b_state2",   cur_state, 3'b010);
        tick();
        tick();
        check("b2b_done2", done, 1'b1);
        check("b2b_err",   err,  1'b0);
        tick();

        // Reset during symbol 2 of a 5-symbol command.
        req_valid = 1'b1;
        req_len   = 4'd5;
        req_seq   = 16'h02AA;
        tick();                         // E0
        req_valid = 1'b0;
        tick();                         // E1
        tick();                         // E2: symbol 2 on x
        check("mid_x_before", x, 1'b1);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_xy",    {x, y},    2'b00);
        check("mid_rst_state", cur_state, 3'b100);
        check("mid_rst_exp",   exp_out,   2'b00);
        check("mid_rst_err",   err,       1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("mid_rst_done", done, 1'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("post_rst_done",  done,      1'b0);
            check("post_rst_ready", req_ready, 1'b1);
        end
        check("post_rst_state", cur_state, 3'b100);
        check("post_rst_exp",   exp_out,   2'b00);

        // Length-0 command after reset.
        req_valid = 1'b1;
        req_len   = 4'd0;
        req_seq   = 16'h0002;
        tick();
        req_valid = 1'b0;
        check("post_rst_len0_done", done,   1'b1);
        check("post_rst_len0_xy",   {x, y}, 2'b00);
        tick();
        check("post_rst_len0_end", done, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm_stim_driver.md
# fsm_stim_driver

Stimulus driver and checker for the three-state x/y control FSM.
- Accepts a command holding a sequence of up to MAXLEN x/y symbols and drives them onto the FSM's `x`/`y` inputs, one per cycle.
- Keeps a shadow model of the FSM's state and registered output, and compares the FSM's `out` against the model one cycle after each symbol takes effect.
- Sits between a test/control sequencer and the FSM, on the input side of the FSM's interface.

## Interface
- `MAXLEN`, 8: maximum symbols per command.
- `LENW`, 4: width of length/index fields; must hold MAXLEN.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  command valid.
- `req_ready`  out  1  block idle and able to accept.
- `req_len`  in  LENW  symbol count, 0..MAXLEN; values above MAXLEN clamp to MAXLEN.
- `req_seq`  in  2*MAXLEN  symbol i at bits [2i+1:2i]:
  - 00 = hold
  - 01 = y
  - 10 = x
  - 11 = x and y
- `x`, `y`  out  1 each  registered drives to the FSM.
- `obs_out`  in  2  FSM registered output.
- `done`  out  1  one-cycle pulse, command complete.
- `err`  out  1  mismatch seen during current/last command.
- `fail_idx`  out  LENW  index of first mismatching symbol.
- `cur_state`  out  3  shadow state, one-hot: A=100, B=010, C=001.
- `exp_out`  out  2  shadow expected FSM output.

## Operation
- Shadow model transitions (y overrides x when both set; hold keeps state and output):
  - A: x -> B / out 10; y -> C / out 01
  - B: x -> C / out 01; y -> A / out 10
  - C: x -> B / out 01; y -> A / out 01
- State machine IDLE -> DRIVE -> DRAIN -> IDLE.
- IDLE
  - `req_ready`=1.
  - Handshake on `req_valid && req_ready`: latch `req_seq` and the clamped length, clear `err` and `fail_idx`, set index=0.
  - len 0: go directly to IDLE and pulse `done` next cycle; no symbols driven, `err`=0.
  - Otherwise go to DRIVE.
- DRIVE
  - `x`/`y` present symbol[index]; shadow state and `exp_out` advance on every symbol.
  - After the last symbol, `x`/`y` return to 0 and the block goes to DRAIN.
- Checking
  - Each symbol's expected output is pipelined and compared to `obs_out` exactly two edges after that symbol is loaded.
  - On the first mismatch: `err`=1 and `fail_idx`=symbol index.
  - Later mismatches set nothing further; `err` stays set until the next accept.
  - Hold symbols are checked too: expected value is the unchanged output.
- DRAIN: waits for the last comparison, pulses `done`, returns to IDLE.
- `req_valid` while `req_ready`=0 is ignored; no queuing.
- `cur_state` and `exp_out` persist across commands; only reset reinitialises them.
- Reset (any time, including mid-command):
  - asynchronously: `x`=`y`=0, `done`=0, `err`=0, `fail_idx`=0, `cur_state`=100, `exp_out`=00, state IDLE, and pending checks discarded.
  - `req_ready`=1 once reset is released.
  - The FSM shares the reset domain and is at A/00 when the first command is accepted.

## Timing
- Edge E0 accepts the command and loads symbol 0 onto `x`/`y`.
- Edge Ek loads symbol k; the FSM samples symbol k at E(k+1).
- `obs_out` for symbol k is compared in the cycle after E(k+1), registered at E(k+2).
- Last symbol (len-1):
  - `x`/`y` cleared at E(len).
  - `done` high in the cycle after E(len+1); `req_ready` high in that same cycle.
- Accept-to-done latency is len+2 edges for len≥1, and 1 edge for len 0.
- `cur_state`/`exp_out` update at the same edge that loads each symbol; final values are valid when `done` is high.
- Throughput: one symbol per cycle. Back-to-back commands are allowed; a new accept may occur in the `done` cycle.

## Test plan
- Reset: hold `rst`=0 mid-idle.
  - Required: `x`=`y`=0, `done`=0, `err`=0, `cur_state`=100, `exp_out`=00.
  - After release: `req_ready`=1.
- Single x from A: len 1, seq 10, FSM connected.
  - Required: `x` high exactly one cycle, `obs_out`=10 matches, `done` pulse at E2, `err`=0, `cur_state`=010.
- Sequence x,x,y,y from A: len 4.
  - Required: expected outputs 10, 01, 01, 01; final `cur_state`=001; `done` at E5; `err`=0.
- Both-asserted symbol: from B, len 1, seq 11.
  - Required: `x`=`y`=1 for one cycle, `cur_state`=100, `exp_out`=10, no error.
- Mismatch injection: len 3, with `obs_out` forced to 11 for the check of symbol 1.
  - Required: `err`=1, `fail_idx`=1, `done` still at E4.
  - Next accept: `err` clears.
- Reset mid-command: assert `rst` during symbol 2 of 5.
  - Required: `x`/`y` drop to 0 immediately and `done` never pulses.
  - After release: `req_ready`=1, `cur_state`=100; a following len-0 command gives a `done` pulse 1 cycle after accept.
